// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and colour width for the VGA display path.
package vga_pkg;

    localparam int VGA_TOTAL_COLS     = 800;
    localparam int VGA_TOTAL_ROWS     = 525;
    localparam int VGA_ACTIVE_COLS    = 640;
    localparam int VGA_ACTIVE_ROWS    = 480;
    localparam int VGA_H_FRONT_PORCH  = 16;
    localparam int VGA_H_SYNC         = 96;
    localparam int VGA_V_FRONT_PORCH  = 10;
    localparam int VGA_V_SYNC         = 2;
    localparam int VGA_FRAMES_PER_TICK = 30;

    localparam int c_COLOR_W = 4;

    // Inclusive sync windows, expressed in the 10-bit count domain.
    localparam logic [9:0] H_SYNC_START = 10'(VGA_ACTIVE_COLS + VGA_H_FRONT_PORCH);
    localparam logic [9:0] H_SYNC_END   = 10'(VGA_ACTIVE_COLS + VGA_H_FRONT_PORCH + VGA_H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(VGA_ACTIVE_ROWS + VGA_V_FRONT_PORCH);
    localparam logic [9:0] V_SYNC_END   = 10'(VGA_ACTIVE_ROWS + VGA_V_FRONT_PORCH + VGA_V_SYNC - 1);

    // True when a count lies inside an inclusive [lo, hi] window.
    function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing/video bundle between the timing generator (master) and renderer/board (slave).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic                 i_Tick_En;
    logic [c_COLOR_W-1:0] i_Red_Video;
    logic [c_COLOR_W-1:0] i_Grn_Video;
    logic [c_COLOR_W-1:0] i_Blu_Video;
    logic [9:0]           o_Col_Count;
    logic [9:0]           o_Row_Count;
    logic                 o_Active;
    logic                 o_Frame_Start;
    logic                 o_Game_Tick;
    logic                 o_HSync;
    logic                 o_VSync;
    logic [c_COLOR_W-1:0] o_Red_Video;
    logic [c_COLOR_W-1:0] o_Grn_Video;
    logic [c_COLOR_W-1:0] o_Blu_Video;

    modport master (
        input  i_Tick_En, i_Red_Video, i_Grn_Video, i_Blu_Video,
        output o_Col_Count, o_Row_Count, o_Active, o_Frame_Start, o_Game_Tick,
               o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video
    );

    modport slave (
        output i_Tick_En, i_Red_Video, i_Grn_Video, i_Blu_Video,
        input  o_Col_Count, o_Row_Count, o_Active, o_Frame_Start, o_Game_Tick,
               o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video
    );

endinterface

// File: rtl/vga_frame_ticker.sv
// Frame divider: emits a one-cycle tick on every c_FRAMES_PER_TICK-th frame start.
// i_Frame_Start is the next-state frame strobe, so o_Tick lines up with o_Frame_Start.
module vga_frame_ticker
    import vga_pkg::*;
#(
    parameter int c_FRAMES_PER_TICK = VGA_FRAMES_PER_TICK
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Frame_Start,
    input  logic i_Tick_En,
    output logic o_Tick
);

    localparam int               c_DIV_W = $clog2(c_FRAMES_PER_TICK) + 1;
    localparam logic [c_DIV_W-1:0] c_LAST = c_DIV_W'(c_FRAMES_PER_TICK - 1);

    logic [c_DIV_W-1:0] r_Div;
    logic               r_Tick;

    // Count enabled frame starts; disabling the ticker discards any partial count.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Div  <= '0;
            r_Tick <= 1'b0;
        end else begin
            r_Tick <= 1'b0;
            if (!i_Tick_En) begin
                r_Div <= '0;
            end else if (i_Frame_Start) begin
                if (r_Div == c_LAST) begin
                    r_Div  <= '0;
                    r_Tick <= 1'b1;
                end else begin
                    r_Div <= r_Div + 1'b1;
                end
            end
        end
    end

    assign o_Tick = r_Tick;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing master: column/row scan, syncs, active flag, frame strobe, game tick
// and a one-cycle blanking stage on the returned pixel colour.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int c_TOTAL_COLS      = VGA_TOTAL_COLS,
    parameter int c_TOTAL_ROWS      = VGA_TOTAL_ROWS,
    parameter int c_ACTIVE_COLS     = VGA_ACTIVE_COLS,
    parameter int c_ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
    parameter int c_H_FRONT_PORCH   = VGA_H_FRONT_PORCH,
    parameter int c_H_SYNC          = VGA_H_SYNC,
    parameter int c_V_FRONT_PORCH   = VGA_V_FRONT_PORCH,
    parameter int c_V_SYNC          = VGA_V_SYNC,
    parameter int c_FRAMES_PER_TICK = VGA_FRAMES_PER_TICK
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    vga_timing_gen_if.master  bus
);

    localparam logic [9:0] c_COL_LAST = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] c_ROW_LAST = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] c_ACT_COLS = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] c_ACT_ROWS = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] c_HS_START = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
    localparam logic [9:0] c_HS_END   = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC - 1);
    localparam logic [9:0] c_VS_START = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
    localparam logic [9:0] c_VS_END   = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC - 1);

    // r_Running is clear while held in reset so the first edge after release presents (0,0).
    logic                 r_Running;
    logic [9:0]           r_Col;
    logic [9:0]           r_Row;
    logic                 r_Active;
    logic                 r_Frame_Start;
    logic                 r_HSync;
    logic                 r_VSync;
    logic [c_COLOR_W-1:0] r_Red;
    logic [c_COLOR_W-1:0] r_Grn;
    logic [c_COLOR_W-1:0] r_Blu;
    logic [9:0]           w_Col_Next;
    logic [9:0]           w_Row_Next;
    logic                 w_Frame_Start_Next;
    logic                 w_Tick;

    // Next scan position: hold (0,0) until running, then advance with column/row wrap.
    always_comb begin
        w_Col_Next = '0;
        w_Row_Next = '0;
        if (r_Running) begin
            if (r_Col == c_COL_LAST) begin
                w_Col_Next = '0;
                w_Row_Next = (r_Row == c_ROW_LAST) ? 10'd0 : r_Row + 10'd1;
            end else begin
                w_Col_Next = r_Col + 10'd1;
                w_Row_Next = r_Row;
            end
        end
    end

    assign w_Frame_Start_Next = (w_Col_Next == 10'd0) && (w_Row_Next == 10'd0);

    // Register scan position, decoded flags, delayed syncs and blanked colour.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Running     <= 1'b0;
            r_Col         <= '0;
            r_Row         <= '0;
            r_Active      <= 1'b0;
            r_Frame_Start <= 1'b0;
            r_HSync       <= 1'b1;
            r_VSync       <= 1'b1;
            r_Red         <= '0;
            r_Grn         <= '0;
            r_Blu         <= '0;
        end else begin
            r_Running     <= 1'b1;
            r_Col         <= w_Col_Next;
            r_Row         <= w_Row_Next;
            r_Active      <= (w_Col_Next < c_ACT_COLS) && (w_Row_Next < c_ACT_ROWS);
            r_Frame_Start <= w_Frame_Start_Next;
            r_HSync       <= !(r_Running && in_window(r_Col, c_HS_START, c_HS_END));
            r_VSync       <= !(r_Running && in_window(r_Row, c_VS_START, c_VS_END));
            r_Red         <= r_Active ? bus.i_Red_Video : '0;
            r_Grn         <= r_Active ? bus.i_Grn_Video : '0;
            r_Blu         <= r_Active ? bus.i_Blu_Video : '0;
        end
    end

    vga_frame_ticker #(
        .c_FRAMES_PER_TICK (c_FRAMES_PER_TICK)
    ) u_ticker (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Frame_Start (w_Frame_Start_Next),
        .i_Tick_En     (bus.i_Tick_En),
        .o_Tick        (w_Tick)
    );

    assign bus.o_Col_Count   = r_Col;
    assign bus.o_Row_Count   = r_Row;
    assign bus.o_Active      = r_Active;
    assign bus.o_Frame_Start = r_Frame_Start;
    assign bus.o_Game_Tick   = w_Tick;
    assign bus.o_HSync       = r_HSync;
    assign bus.o_VSync       = r_VSync;
    assign bus.o_Red_Video   = r_Red;
    assign bus.o_Grn_Video   = r_Grn;
    assign bus.o_Blu_Video   = r_Blu;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance (full frames, ticks, vsync)
// and a default 640x480 instance (line timing), both against a cycle-count model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    logic tb_en = 1'b1;
    logic [3:0] tb_r = '0, tb_g = '0, tb_b = '0;
    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_s ();
    vga_timing_gen_if if_d ();

    assign if_s.i_Tick_En = tb_en;
    assign if_s.i_Red_Video = tb_r;
    assign if_s.i_Grn_Video = tb_g;
    assign if_s.i_Blu_Video = tb_b;
    assign if_d.i_Tick_En = tb_en;
    assign if_d.i_Red_Video = tb_r;
    assign if_d.i_Grn_Video = tb_g;
    assign if_d.i_Blu_Video = tb_b;

    vga_timing_gen #(
        .c_TOTAL_COLS (40), .c_TOTAL_ROWS (20), .c_ACTIVE_COLS (30), .c_ACTIVE_ROWS (12),
        .c_H_FRONT_PORCH (2), .c_H_SYNC (4), .c_V_FRONT_PORCH (2), .c_V_SYNC (2),
        .c_FRAMES_PER_TICK (3)
    ) dut_s (.i_Clk (clk), .i_Rst (tb_rst), .bus (if_s));

    vga_timing_gen dut_d (.i_Clk (clk), .i_Rst (tb_rst), .bus (if_d));

    // Model geometry per instance: 0 = reduced, 1 = default.
    int P_TC[2] = '{40, 800};
    int P_TR[2] = '{20, 525};
    int P_AC[2] = '{30, 640};
    int P_AR[2] = '{12, 480};
    int P_HFP[2] = '{2, 16};
    int P_HS[2] = '{4, 96};
    int P_VFP[2] = '{2, 10};
    int P_VS[2] = '{2, 2};
    int P_F[2] = '{3, 30};
    string NM[2] = '{"small", "dflt"};

    int m_k[2] = '{-1, -1};
    int m_div[2] = '{0, 0};
    int e_col[2], e_row[2], e_r[2], e_g[2], e_b[2];
    bit e_act[2], e_fs[2], e_tick[2], e_hs[2], e_vs[2];
    int n_ticks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after one edge, from elapsed cycles since reset release.
    task automatic model_update(input int id);
        int pos, pc, pr;
        bit pa, run;
        if (tb_rst) begin
            m_k[id] = -1; m_div[id] = 0;
            e_col[id] = 0; e_row[id] = 0; e_act[id] = 0; e_fs[id] = 0; e_tick[id] = 0;
            e_hs[id] = 1; e_vs[id] = 1; e_r[id] = 0; e_g[id] = 0; e_b[id] = 0;
        end else begin
            run = (m_k[id] >= 0);
            pc = e_col[id]; pr = e_row[id]; pa = e_act[id];
            e_hs[id] = !(run && pc >= P_AC[id] + P_HFP[id] && pc < P_AC[id] + P_HFP[id] + P_HS[id]);
            e_vs[id] = !(run && pr >= P_AR[id] + P_VFP[id] && pr < P_AR[id] + P_VFP[id] + P_VS[id]);
            e_r[id] = pa ? int'(tb_r) : 0;
            e_g[id] = pa ? int'(tb_g) : 0;
            e_b[id] = pa ? int'(tb_b) : 0;
            m_k[id]++;
            pos = m_k[id] % (P_TC[id] * P_TR[id]);
            e_col[id] = pos % P_TC[id];
            e_row[id] = pos / P_TC[id];
            e_act[id] = (e_col[id] < P_AC[id]) && (e_row[id] < P_AR[id]);
            e_fs[id] = (pos == 0);
            e_tick[id] = 0;
            if (!tb_en) m_div[id] = 0;
            else if (e_fs[id]) begin
                if (m_div[id] == P_F[id] - 1) begin
                    e_tick[id] = 1; m_div[id] = 0;
                end else m_div[id]++;
            end
        end
    endtask

    task automatic check_inst(input int id, input logic [9:0] col, input logic [9:0] row,
                              input logic act, input logic fs, input logic tk,
                              input logic hs, input logic vs,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        check_val({NM[id], ".col"}, col, e_col[id]);
        check_val({NM[id], ".row"}, row, e_row[id]);
        check_val({NM[id], ".active"}, act, e_act[id]);
        check_val({NM[id], ".frame_start"}, fs, e_fs[id]);
        check_val({NM[id], ".game_tick"}, tk, e_tick[id]);
        check_val({NM[id], ".hsync"}, hs, e_hs[id]);
        check_val({NM[id], ".vsync"}, vs, e_vs[id]);
        check_val({NM[id], ".red"}, r, e_r[id]);
        check_val({NM[id], ".grn"}, g, e_g[id]);
        check_val({NM[id], ".blu"}, b, e_b[id]);
    endtask

    task automatic step(input bit rand_col);
        @(posedge clk);
        model_update(0);
        model_update(1);
        if (e_tick[0]) n_ticks++;
        @(negedge clk);
        check_inst(0, if_s.o_Col_Count, if_s.o_Row_Count, if_s.o_Active, if_s.o_Frame_Start,
                   if_s.o_Game_Tick, if_s.o_HSync, if_s.o_VSync,
                   if_s.o_Red_Video, if_s.o_Grn_Video, if_s.o_Blu_Video);
        check_inst(1, if_d.o_Col_Count, if_d.o_Row_Count, if_d.o_Active, if_d.o_Frame_Start,
                   if_d.o_Game_Tick, if_d.o_HSync, if_d.o_VSync,
                   if_d.o_Red_Video, if_d.o_Grn_Video, if_d.o_Blu_Video);
        if (rand_col) begin
            tb_r = 4'($urandom); tb_g = 4'($urandom); tb_b = 4'($urandom);
        end
    endtask

    initial begin
        int budget;
        tb_r = 4'hF; tb_g = 4'hF; tb_b = 4'hF;
        repeat (5) step(1'b0);
        @(negedge clk);
        tb_rst = 1'b0;
        // Constant white for two reduced frames, ticks enabled through nine frame starts.
        repeat (1600) step(1'b0);
        repeat (5610) step(1'b1);
        check_val("small.ticks_9_frames", n_ticks, 3);
        // Drop tick enable across one frame start, then re-enable for three more.
        tb_en = 1'b0;
        repeat (800) step(1'b1);
        tb_en = 1'b1;
        repeat (2410) step(1'b1);
        check_val("small.ticks_after_reenable", n_ticks, 4);
        // Random enable toggling.
        repeat (800) begin
            step(1'b1);
            if ($urandom_range(0, 99) == 0) tb_en = ~tb_en;
        end
        tb_en = 1'b1;
        // Mid-frame reset at (col 20, row 5) of the reduced instance.
        budget = 0;
        while (!(e_col[0] == 20 && e_row[0] == 5) && budget < 1000) begin
            step(1'b1);
            budget++;
        end
        check_val("small.reach_reset_point", budget < 1000, 1);
        tb_rst = 1'b1;
        repeat (2) step(1'b1);
        tb_rst = 1'b0;
        repeat (1700) step(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Master VGA timing source for the Snake display path. It generates free-running column/row counters with correctly placed HSync/VSync pulses, an active-video flag and a frame-start strobe. It divides frames down into a single-cycle game-step tick that drives the game-logic advance input. It also applies a one-cycle blanking stage to the pixel colour stream returned by the renderer, so the board sees black during porches and sync.

Parameters:
c_TOTAL_COLS, 800, pixel clocks per line
c_TOTAL_ROWS, 525, lines per frame
c_ACTIVE_COLS, 640, visible pixels per line
c_ACTIVE_ROWS, 480, visible lines per frame
c_H_FRONT_PORCH, 16, clocks between end of active and HSync start
c_H_SYNC, 96, HSync pulse width in clocks (back porch = remainder, 48)
c_V_FRONT_PORCH, 10, lines between end of active and VSync start
c_V_SYNC, 2, VSync pulse width in lines
c_FRAMES_PER_TICK, 30, frames per game-step tick (>=1)

Ports:
i_Clk  in  1  pixel clock (25.175 MHz nominal)
i_Rst  in  1  synchronous reset, active-high
i_Tick_En  in  1  1 = game ticks enabled; 0 = frame divider held at 0
i_Red_Video  in  4  renderer red, valid for the o_Col_Count/o_Row_Count of the same cycle
i_Grn_Video  in  4  renderer green, same timing
i_Blu_Video  in  4  renderer blue, same timing
o_Col_Count  out  10  current column, 0..c_TOTAL_COLS-1
o_Row_Count  out  10  current row, 0..c_TOTAL_ROWS-1
o_Active  out  1  1 when col < c_ACTIVE_COLS and row < c_ACTIVE_ROWS
o_Frame_Start  out  1  1-cycle pulse at (col 0, row 0)
o_Game_Tick  out  1  1-cycle pulse every c_FRAMES_PER_TICK frames
o_HSync  out  1  active-low, delayed 1 cycle to align with blanked video
o_VSync  out  1  active-low, delayed 1 cycle
o_Red_Video  out  4  blanked red
o_Grn_Video  out  4  blanked green
o_Blu_Video  out  4  blanked blue

Behaviour:
- One clock (i_Clk); reset is synchronous and active-high (i_Rst). All outputs are registered.
- Reset values: counts 0; o_Active 0; o_Frame_Start 0; o_Game_Tick 0; o_HSync 1; o_VSync 1; colour outputs 0; frame divider 0.
- Reset mid-frame: on the next edge, all outputs return to their reset values. The counters restart at (0,0) on the first edge after i_Rst falls.
- First edge after reset release: counts (0,0), o_Active=1, o_Frame_Start=1. Counters then advance by one column per clock.
- Column wraps at c_TOTAL_COLS-1 back to 0. The row increments only on the column wrap, and wraps at c_TOTAL_ROWS-1 back to 0. A frame is exactly 420000 clocks at the defaults.
- Count-aligned sync: the internal sync is low for col in [c_ACTIVE_COLS+c_H_FRONT_PORCH, +c_H_SYNC-1], i.e. 656..751, on every row. VSync is low for rows 490..491 across the entire line.
- Output stage, 1-cycle latency:
  - o_HSync and o_VSync are the internal syncs delayed one clock.
  - o_*_Video <= o_Active ? i_*_Video : 0. Inputs are sampled with the o_Active of the same cycle.
- o_Frame_Start is high exactly when the registered counts equal (0,0).
- Frame divider:
  - Counts o_Frame_Start events while i_Tick_En=1.
  - On a frame start with divider == c_FRAMES_PER_TICK-1: o_Game_Tick=1 on the same cycle as o_Frame_Start, and the divider clears.
  - c_FRAMES_PER_TICK=1 produces a tick every frame.
  - i_Tick_En=0 clears the divider and suppresses ticks.
  - If i_Tick_En rises coincident with a frame start, that frame counts.
- Arithmetic: all counters are unsigned. The divider width is $clog2(c_FRAMES_PER_TICK)+1. Sync windows are compared using 10-bit constants only.

Decomposition:
- Package vga_pkg:
  - 640x480@60 default timing constants.
  - Derived constants: H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END.
  - Colour width constant of 4.
- Sub-module vga_frame_ticker: the frame divider. Inputs: i_Clk, i_Rst, i_Frame_Start, i_Tick_En. Output: o_Tick.

Test Plan:
- Reset held 5 cycles, then released -> first edge shows counts (0,0), o_Frame_Start=1, o_Active=1. The next o_Frame_Start occurs exactly 420000 clocks later.
- Row 0 scan -> o_Active=1 for cols 0..639 and 0 for 640..799. o_HSync low for exactly 96 clocks, first low one clock after col 656 is presented.
- Frame scan -> o_VSync low for exactly 1600 clocks (rows 490-491), starting one clock after (col 0, row 490).
- Constant input colour (15,15,15) -> output is (15,15,15) only one cycle after active counts, and 0 during every blanked count.
- i_Tick_En=1, c_FRAMES_PER_TICK=3 -> o_Game_Tick on the 3rd, 6th and 9th frame starts. Dropping i_Tick_En for one frame restarts the count, so the next tick is 3 frames after re-enable.
- i_Rst asserted at (col 300, row 200) -> next edge shows all outputs at reset values. After release, counts restart at (0,0) and the divider is 0.
